// File: rtl/rv_iommu_ddtp_fence_ctrl.sv
// DDTP rewrite quiesce sequencer: block new requests, drain, flush the IOATC, then report idle.
// Optional drain watchdog is compiled in with IOMMU_FENCE_TIMEOUT_EN.
module rv_iommu_ddtp_fence_ctrl #(
  parameter int unsigned OUTSTANDING_W  = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_req_i,
  input  logic                     req_issue_i,
  input  logic                     req_complete_i,
  input  logic                     pgwk_busy_i,
  input  logic                     flush_ack_i,
  output logic                     block_o,
  output logic                     flush_req_o,
  output logic                     idle_o,
  output logic [OUTSTANDING_W-1:0] outstanding_o,
  output logic                     cnt_err_o,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [OUTSTANDING_W-1:0] CNT_MAX  = '1;
  localparam logic [OUTSTANDING_W-1:0] CNT_ZERO = '0;
  localparam logic [OUTSTANDING_W-1:0] CNT_ONE  = {{(OUTSTANDING_W-1){1'b0}}, 1'b1};

  state_e                   r_state;
  logic [OUTSTANDING_W-1:0] r_count;
  logic [OUTSTANDING_W-1:0] w_countNext;
  logic                     w_inc;
  logic                     w_dec;
  logic                     w_ovf;
  logic                     w_unf;
  logic                     w_drained;
  logic                     w_wdogFire;

  assign w_inc = req_issue_i & ~req_complete_i;
  assign w_dec = req_complete_i & ~req_issue_i;

  // Saturating in-flight count; a clamped step is a protocol error, not a wrap.
  always_comb begin
    w_countNext = r_count;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    if (w_inc) begin
      if (r_count == CNT_MAX) w_ovf = 1'b1;
      else                    w_countNext = r_count + CNT_ONE;
    end else if (w_dec) begin
      if (r_count == CNT_ZERO) w_unf = 1'b1;
      else                     w_countNext = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= CNT_ZERO;
      cnt_err_o <= 1'b0;
    end else begin
      r_count <= w_countNext;
      if (w_ovf || w_unf) cnt_err_o <= 1'b1;
    end
  end

  assign outstanding_o = r_count;

  // An issue in the exit cycle blocks the exit even when a matching completion keeps the count at zero.
  assign w_drained = (w_countNext == CNT_ZERO) && !pgwk_busy_i && !req_issue_i;

`ifdef IOMMU_FENCE_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;

  assign w_wdogFire = (r_state == S_DRAIN) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != S_DRAIN) r_wdog <= '0;
      else                    r_wdog <= r_wdog + 1'b1;
      if (w_wdogFire && stall_req_i && !w_drained) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_wdogFire = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      block_o     <= 1'b0;
      flush_req_o <= 1'b0;
      idle_o      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (stall_req_i) begin
            r_state <= S_DRAIN;
            block_o <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!stall_req_i) begin
            r_state <= S_IDLE;
            block_o <= 1'b0;
          end else if (w_drained || w_wdogFire) begin
            r_state     <= S_FLUSH;
            flush_req_o <= 1'b1;
          end
        end
        // Once requested, the flush always completes even if the stall is withdrawn.
        S_FLUSH: begin
          if (flush_ack_i) begin
            flush_req_o <= 1'b0;
            if (stall_req_i) begin
              r_state <= S_DONE;
              idle_o  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              block_o <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (!stall_req_i) begin
            r_state <= S_IDLE;
            block_o <= 1'b0;
            idle_o  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          block_o     <= 1'b0;
          flush_req_o <= 1'b0;
          idle_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iommu_ddtp_fence_ctrl.sv
// Randomized plus directed bench for rv_iommu_ddtp_fence_ctrl against a behavioural quiesce model.
module tb_rv_iommu_ddtp_fence_ctrl;

  localparam int OW = 6;
`ifdef IOMMU_FENCE_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif
  localparam int MAXC = (1 << OW) - 1;

  logic          clk;
  logic          rst_n;
  logic          stallReq;
  logic          reqIssue;
  logic          reqComplete;
  logic          pgwkBusy;
  logic          flushAck;
  logic          blockOut;
  logic          flushReq;
  logic          idleOut;
  logic [OW-1:0] outstanding;
  logic          cntErr;
  logic          timeoutOut;

  int checks   = 0;
  int failures = 0;

  // Model: sequencing described as "blocked / flushing / idle reported" flags plus a plain integer count.
  int mCount;
  bit mErr;
  bit mTimeout;
  bit mBlock;
  bit mFlush;
  bit mIdle;
  int mDrainCycles;

  rv_iommu_ddtp_fence_ctrl #(
    .OUTSTANDING_W (OW),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_req_i   (stallReq),
    .req_issue_i   (reqIssue),
    .req_complete_i(reqComplete),
    .pgwk_busy_i   (pgwkBusy),
    .flush_ack_i   (flushAck),
    .block_o       (blockOut),
    .flush_req_o   (flushReq),
    .idle_o        (idleOut),
    .outstanding_o (outstanding),
    .cnt_err_o     (cntErr),
    .timeout_o     (timeoutOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mCount       = 0;
    mErr         = 1'b0;
    mTimeout     = 1'b0;
    mBlock       = 1'b0;
    mFlush       = 1'b0;
    mIdle        = 1'b0;
    mDrainCycles = 0;
  endfunction

  function automatic void modelStep(input bit stall, input bit issue, input bit complete,
                                    input bit busy, input bit ack);
    int  nc;
    bit  draining;
    draining = mBlock && !mFlush && !mIdle;
    nc = mCount + int'(issue) - int'(complete);
    if (nc > MAXC) begin nc = MAXC; mErr = 1'b1; end
    if (nc < 0)    begin nc = 0;    mErr = 1'b1; end
    if (!mBlock) begin
      if (stall) begin mBlock = 1'b1; mDrainCycles = 0; end
    end else if (draining) begin
      mDrainCycles++;
      if (!stall) mBlock = 1'b0;
      else if (nc == 0 && !busy && !issue) mFlush = 1'b1;
`ifdef IOMMU_FENCE_TIMEOUT_EN
      else if (mDrainCycles >= TB_TIMEOUT) begin mFlush = 1'b1; mTimeout = 1'b1; end
`endif
    end else if (mFlush) begin
      if (ack) begin
        mFlush = 1'b0;
        if (stall) mIdle = 1'b1;
        else       mBlock = 1'b0;
      end
    end else if (mIdle) begin
      if (!stall) begin mIdle = 1'b0; mBlock = 1'b0; end
    end
    mCount = nc;
  endfunction

  task automatic checkAll(input string where);
    checkOutput({where, ".block"},  32'(blockOut),    32'(mBlock));
    checkOutput({where, ".flush"},  32'(flushReq),    32'(mFlush));
    checkOutput({where, ".idle"},   32'(idleOut),     32'(mIdle));
    checkOutput({where, ".count"},  32'(outstanding), 32'(mCount));
    checkOutput({where, ".cntErr"}, 32'(cntErr),      32'(mErr));
    checkOutput({where, ".tmo"},    32'(timeoutOut),  32'(mTimeout));
  endtask

  // One clock: drive inputs just after the falling edge, update the model, check at the next falling edge.
  task automatic applyStimulus(input bit stall, input bit issue, input bit complete,
                               input bit busy, input bit ack, input string where);
    stallReq    = stall;
    reqIssue    = issue;
    reqComplete = complete;
    pgwkBusy    = busy;
    flushAck    = ack;
    modelStep(stall, issue, complete, busy, ack);
    @(negedge clk);
    checkAll(where);
  endtask

  initial begin
    bit stall;
    bit busy;
    bit issue;
    bit cpl;
    bit ack;

    rst_n = 1'b0;
    stallReq = 1'b0; reqIssue = 1'b0; reqComplete = 1'b0; pgwkBusy = 1'b0; flushAck = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    // Minimum latency with same-cycle ack, then release.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, "minLatPre");
    for (int i = 0; i < 4; i++)  applyStimulus(1, 0, 0, 0, 1, "minLat");
    checkOutput("minLatIdle", 32'(idleOut), 32'd1);
    for (int i = 0; i < 3; i++)  applyStimulus(0, 0, 0, 0, 0, "minLatDrop");
    checkOutput("minLatBlockDrop", 32'(blockOut), 32'd0);

    // Three in flight, staggered completions, walker busy for a while.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, "drainIssue");
    for (int k = 0; k < 30; k++)
      applyStimulus(1, 0, (k == 5) || (k == 9) || (k == 20), k < 25, 0, "drainWait");
    checkOutput("drainFlushReq", 32'(flushReq), 32'd1);
    checkOutput("drainCountZero", 32'(outstanding), 32'd0);
    applyStimulus(1, 0, 0, 0, 1, "drainAck");
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, "drainRelease");

    // Simultaneous issue and complete at count 2 keeps the count and stays in drain.
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0, "simIssue");
    applyStimulus(1, 0, 0, 0, 0, "simStall");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, "simBoth");
    checkOutput("simCount", 32'(outstanding), 32'd2);
    checkOutput("simNoFlush", 32'(flushReq), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, "simCpl");
    applyStimulus(1, 0, 0, 0, 1, "simAck");
    applyStimulus(0, 0, 0, 0, 0, "simRelease");
    applyStimulus(0, 0, 0, 0, 0, "simRelease");

    // Abort during drain, then abort during flush (flush still completes, idle never reported).
    applyStimulus(0, 1, 0, 0, 0, "abortIssue");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, "abortDrain");
    applyStimulus(0, 0, 1, 0, 0, "abortDrop");
    applyStimulus(0, 0, 0, 0, 0, "abortIdle");
    checkOutput("abortNoFlush", 32'(flushReq), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, "abortToFlush");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "abortHold");
    checkOutput("abortFlushHeld", 32'(flushReq), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, "abortAck");
    checkOutput("abortNoIdle", 32'(idleOut), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, "abortAfter");

    // Random traffic; issues are rare while blocked so that drains can complete.
    stall = 1'b0;
    busy  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) stall = ~stall;
      if ($urandom_range(9) == 0)  busy  = ~busy;
      issue = mBlock ? ($urandom_range(49) == 0) : ($urandom_range(2) == 0);
      cpl   = (mCount > 0) ? ($urandom_range(2) == 0) : ($urandom_range(59) == 0);
      ack   = ($urandom_range(3) == 0);
      applyStimulus(stall, issue, cpl, busy, ack, "rand");
    end

    // Asynchronous reset in the middle of a pending flush.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, (mCount > 0), 0, 0, "midRstSetup");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, (mCount > 0), 0, 0, "midRstSetup");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("midRst");
    stallReq = 1'b0; reqIssue = 1'b0; reqComplete = 1'b0; pgwkBusy = 1'b0; flushAck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, "postRst");

    // Underflow, then overflow to saturation.
    applyStimulus(0, 0, 1, 0, 0, "underflow");
    checkOutput("underflowErr", 32'(cntErr), 32'd1);
    checkOutput("underflowCount", 32'(outstanding), 32'd0);
    for (int i = 0; i < 64; i++) applyStimulus(0, 1, 0, 0, 0, "overflow");
    checkOutput("satCount", 32'(outstanding), 32'd63);
    for (int i = 0; i < 62; i++) applyStimulus(0, 0, 1, 0, 0, "unwind");

    // Count stuck at 1 under stall: watchdog forces a flush if built in, otherwise drain waits.
    for (int i = 0; i < 2000; i++) applyStimulus(1, 0, 0, 0, 0, "stuck");
`ifdef IOMMU_FENCE_TIMEOUT_EN
    checkOutput("stuckTimeout", 32'(timeoutOut), 32'd1);
`else
    checkOutput("stuckStillDrain", 32'(flushReq), 32'd0);
    checkOutput("stuckNoTimeout", 32'(timeoutOut), 32'd0);
`endif
    applyStimulus(0, 0, 1, 0, 1, "stuckRelease");
    applyStimulus(0, 0, 0, 0, 1, "stuckEnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_iommu_ddtp_fence_ctrl.md
# rv_iommu_ddtp_fence_ctrl

Sequences the quiesce required when software rewrites DDTP: on a stall request from the MMIO block it blocks new translation requests, drains in-flight requests and the page walker, flushes the IOATC, then reports idle so the MMIO block can commit the new DDTP to the page-walk shadow copy. It sits between rv_iommu_mmio (stall_req/idle), the request front-end (issue/complete/block), the page walker (busy) and the IOATC (flush handshake).

## Interface
- OUTSTANDING_W, 6: width of the outstanding-request counter; maximum tracked count is 2^OUTSTANDING_W-1.
- TIMEOUT_CYCLES, 1024: drain watchdog limit in cycles; used only when IOMMU_FENCE_TIMEOUT_EN is defined.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_req_i  in  1  level; high while DDTP busy (from MMIO ddtp_pgwk_stall_req_o).
- req_issue_i  in  1  one-cycle pulse per translation request accepted by the front-end.
- req_complete_i  in  1  one-cycle pulse per translation response returned.
- pgwk_busy_i  in  1  page walker has a walk in progress.
- flush_ack_i  in  1  IOATC flush-complete pulse.
- block_o  out  1  front-end must not accept new requests while high.
- flush_req_o  out  1  IOATC invalidate-all request, held until acknowledged.
- idle_o  out  1  quiesce complete (to MMIO ddtp_pgwk_idle_i).
- outstanding_o  out  OUTSTANDING_W  current in-flight request count.
- cnt_err_o  out  1  sticky: counter overflow or underflow seen.
- timeout_o  out  1  sticky: drain watchdog fired (0 when feature compiled out).

## Operation
- States: IDLE, DRAIN, FLUSH, DONE. All outputs registered.
- Counter: +1 on req_issue_i, -1 on req_complete_i, unchanged when both in the same cycle; counts in every state.
- Overflow (issue alone at max): hold at max, set cnt_err_o. Underflow (complete alone at 0): hold at 0, set cnt_err_o.
- IDLE: block_o=0, flush_req_o=0, idle_o=0. stall_req_i high -> DRAIN.
- DRAIN: block_o=1. Exit to FLUSH when next-count==0 and pgwk_busy_i==0 in the same cycle; an issue pulse in that cycle prevents the exit. stall_req_i low -> IDLE (abort, no flush).
- FLUSH: block_o=1, flush_req_o=1. flush_ack_i high -> DONE if stall_req_i high, else IDLE. Flush is never abandoned; stall_req_i dropping does not deassert flush_req_o before ack.
- DONE: block_o=1, idle_o=1. stall_req_i low -> IDLE. A new stall_req_i rise is only recognised after returning to IDLE.
- req_issue_i while block_o=1 is a protocol violation; it is still counted and delays the drain.
- cnt_err_o and timeout_o cleared only by reset.

## Timing
- Reset: state IDLE, counter 0, block_o=0, flush_req_o=0, idle_o=0, cnt_err_o=0, timeout_o=0.
- stall_req_i sampled high in cycle N -> block_o high in N+1.
- Minimum latency (count 0, walker idle, ack same cycle as request): stall high N, DRAIN N+1, flush_req_o high N+2, ack N+2, idle_o high N+3.
- flush_req_o drops the cycle after flush_ack_i is sampled; flush_ack_i outside FLUSH is ignored.
- idle_o stays high until the cycle after stall_req_i is sampled low; block_o drops the same cycle.
- Asynchronous reset mid-sequence returns to IDLE immediately; any pending IOATC request is dropped.

## Configuration
- IOMMU_FENCE_TIMEOUT_EN defined: cycle counter runs in DRAIN (cleared on entry); after TIMEOUT_CYCLES cycles without exit, force FLUSH and set timeout_o. Counter value is retained.
- Undefined: no watchdog logic; DRAIN waits indefinitely; timeout_o tied 0.

## Test plan
- Count 0, walker idle, stall rise at cycle 10, ack in same cycle as flush_req_o -> block_o at 11, flush_req_o at 12, idle_o at 13; stall drop -> block_o and idle_o 0 one cycle later.
- 3 issues, then stall; completions at +5, +9, +20 with pgwk_busy_i high until +25 -> flush_req_o rises at +26, outstanding_o 3->0.
- Simultaneous issue and complete at count 2 during DRAIN -> count stays 2, no FLUSH entry.
- stall drop mid-DRAIN -> IDLE, no flush_req_o; stall drop mid-FLUSH -> flush_req_o held until ack, then IDLE, idle_o never asserted.
- Complete at count 0 -> count 0, cnt_err_o=1; 64 issues with OUTSTANDING_W=6 -> saturate at 63, cnt_err_o=1.
- With IOMMU_FENCE_TIMEOUT_EN, TIMEOUT_CYCLES=16, count stuck at 1 -> FLUSH after 16 DRAIN cycles, timeout_o=1; without the macro, still in DRAIN after 2000 cycles.
